// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and access sequencer in front of a single-port,
// synchronous-read data memory. Two requesters share the memory. Each access runs
// IDLE -> ACCESS -> (MERGE) -> DONE. Sub-word stores are done as read-modify-write
// through MERGE.
//
// Ports:
//   clk, rst                       clock (rising edge), asynchronous active-high reset
//   mN_req/we/addr/wdata/be        requester N command; held stable until mN_gnt
//   mN_gnt                         combinational accept, only in IDLE
//   mN_done/rdata/err              one-cycle completion; rdata valid for loads only
//   mem_address/data_in/we         memory command pins
//   mem_data_out                   memory read data, valid the cycle after the read
//
// Optional feature: define DMEM_ARB_RMW_EN to honour byte enables with a
// read-modify-write. Without it, every store writes the full word.
module dmem_arbiter #(
    parameter int unsigned MEM_WORDS = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_be,
    output logic        m0_gnt,
    output logic        m0_done,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_be,
    output logic        m1_gnt,
    output logic        m1_done,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_we,
    input  logic [31:0] mem_data_out
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
`ifdef DMEM_ARB_RMW_EN
    localparam logic [1:0] S_MERGE  = 2'd2;
`endif
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]  r_state;
    logic        r_last;   // port granted last; 1 = port 1
    logic        r_port;   // owner of the transaction in flight
    logic        r_we;
    logic [29:0] r_word;
    logic [31:0] r_wdata;
    logic        r_err;
`ifdef DMEM_ARB_RMW_EN
    logic [3:0]  r_be;
    logic        w_partial;
    logic [31:0] w_merged;
`endif

    logic [1:0]  w_state_d;
    logic        w_idle;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_accept;
    logic        w_oor;
    logic        w_done;
    logic        w_mem_we;
    logic [31:0] w_mem_din;
    logic [31:0] w_rdata;
    logic        w_unused;

    // Byte offset bits never matter; byte enables only matter with RMW built in.
`ifdef DMEM_ARB_RMW_EN
    assign w_unused = ^{m0_addr[1:0], m1_addr[1:0]};
`else
    assign w_unused = ^{m0_addr[1:0], m1_addr[1:0], m0_be, m1_be};
`endif

    assign w_idle   = (r_state == S_IDLE);
    // On a tie the port not granted last wins.
    assign w_gnt0   = w_idle & m0_req & (~m1_req | r_last);
    assign w_gnt1   = w_idle & m1_req & (~m0_req | ~r_last);
    assign w_accept = w_gnt0 | w_gnt1;
    assign w_oor    = {2'b00, r_word} >= MEM_WORDS;
    assign w_done   = (r_state == S_DONE);

`ifdef DMEM_ARB_RMW_EN
    assign w_partial = (r_be != 4'hF) && (r_be != 4'h0);
    always_comb begin
        w_merged = mem_data_out;
        for (int i = 0; i < 4; i++) begin
            if (r_be[i]) begin
                w_merged[8*i +: 8] = r_wdata[8*i +: 8];
            end
        end
    end
`endif

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
`ifdef DMEM_ARB_RMW_EN
                if (!w_oor && r_we && w_partial) begin
                    w_state_d = S_MERGE;
                end else begin
                    w_state_d = S_DONE;
                end
`else
                w_state_d = S_DONE;
`endif
            end
`ifdef DMEM_ARB_RMW_EN
            S_MERGE: w_state_d = S_DONE;
`endif
            S_DONE:  w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_mem_we  = 1'b0;
        w_mem_din = 32'h0;
        if (r_state == S_ACCESS && !w_oor && r_we) begin
`ifdef DMEM_ARB_RMW_EN
            // Partial stores only read here; empty stores do nothing.
            if (r_be == 4'hF) begin
                w_mem_we  = 1'b1;
                w_mem_din = r_wdata;
            end
`else
            w_mem_we  = 1'b1;
            w_mem_din = r_wdata;
`endif
        end
`ifdef DMEM_ARB_RMW_EN
        if (r_state == S_MERGE) begin
            w_mem_we  = 1'b1;
            w_mem_din = w_merged;
        end
`endif
    end

    // Gate with rst so a write in flight is killed the instant reset rises.
    assign mem_we      = w_mem_we & ~rst;
    assign mem_data_in = w_mem_din;
    assign mem_address = {r_word, 2'b00};

    assign w_rdata  = (w_done && !r_we && !r_err) ? mem_data_out : 32'h0;
    assign m0_gnt   = w_gnt0;
    assign m1_gnt   = w_gnt1;
    assign m0_done  = w_done & ~r_port;
    assign m1_done  = w_done & r_port;
    assign m0_err   = w_done & ~r_port & r_err;
    assign m1_err   = w_done & r_port & r_err;
    assign m0_rdata = r_port ? 32'h0 : w_rdata;
    assign m1_rdata = r_port ? w_rdata : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_port  <= 1'b0;
            r_we    <= 1'b0;
            r_word  <= 30'h0;
            r_wdata <= 32'h0;
            r_err   <= 1'b0;
`ifdef DMEM_ARB_RMW_EN
            r_be    <= 4'h0;
`endif
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_port  <= w_gnt1;
                r_last  <= w_gnt1;
                r_we    <= w_gnt1 ? m1_we : m0_we;
                r_word  <= w_gnt1 ? m1_addr[31:2] : m0_addr[31:2];
                r_wdata <= w_gnt1 ? m1_wdata : m0_wdata;
`ifdef DMEM_ARB_RMW_EN
                r_be    <= w_gnt1 ? m1_be : m0_be;
`endif
            end
            if (r_state == S_ACCESS) begin
                r_err <= w_oor;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, reset-abort and tie sequences,
// then random single-port traffic checked against a word-array reference model.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RMW_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_address, mem_data_in, mem_data_out;
    logic        mem_we;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_WORDS(512)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_be(m0_be), .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
        .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_be(m1_be), .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
        .m1_err(m1_err),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_we(mem_we),
        .mem_data_out(mem_data_out)
    );

    // Synchronous-read single-port memory.
    logic [31:0] mem [512] = '{default: 32'h0};
    logic [31:0] ref_mem [512];
    int          we_cnt = 0;

    always @(posedge clk) begin
        if (mem_we) begin
            we_cnt <= we_cnt + 1;
            if (mem_address[31:2] < 30'd512) mem[mem_address[10:2]] <= mem_data_in;
        end
        mem_data_out <= (mem_address[31:2] < 30'd512) ? mem[mem_address[10:2]] : 32'h0;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: a store overwrites the enabled bytes of the word.
    task automatic ref_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, output logic [31:0] rd, output logic er,
                           output int lat, output int nw);
        int idx;
        idx = int'(addr >> 2);
        rd = 32'h0; er = 1'b0; lat = 2; nw = 0;
        if (idx >= 512) begin
            er = 1'b1;
        end else if (!we) begin
            rd = ref_mem[idx];
        end else if (!RMW || be == 4'hF) begin
            ref_mem[idx] = wdata;
            nw = 1;
        end else if (be != 4'h0) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            lat = 3;
            nw = 1;
        end
    endtask

    task automatic drive(input int p, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input logic req);
        if (p == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be;
        end
    endtask

    task automatic txn(input string name, input int p, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       output logic [31:0] rd, output logic er, output int lat);
        logic got;
        got = 1'b0; rd = 32'h0; er = 1'b0; lat = -1;
        @(negedge clk);
        drive(p, we, addr, wdata, be, 1'b1);
        for (int c = 0; c < 20; c++) begin
            #1;
            if ((p == 0 ? m1_gnt : m0_gnt) == 1'b1) chk({name, "_gnt_other"}, 32'd1, 32'd0);
            if ((p == 0 ? m0_gnt : m1_gnt) == 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({name, "_gnt"}, 32'(got), 32'd1);
        @(negedge clk);
        drive(p, we, addr, wdata, be, 1'b0);
        if (got) begin
            for (int c = 1; c <= 8; c++) begin
                if ((p == 0 ? m0_done : m1_done) == 1'b1) begin
                    lat = c;
                    rd = (p == 0) ? m0_rdata : m1_rdata;
                    er = (p == 0) ? m0_err : m1_err;
                    chk({name, "_other_quiet"}, (p == 0) ?
                        (m1_rdata | {30'h0, m1_done, m1_err}) :
                        (m0_rdata | {30'h0, m0_done, m0_err}), 32'h0);
                    break;
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic run_check(input string name, input int p, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, input logic [31:0] exp_rd,
                             input logic exp_er, input int exp_lat, input int exp_nw);
        logic [31:0] rd;
        logic        er;
        int          lat, w0, idx;
        w0 = we_cnt;
        txn(name, p, we, addr, wdata, be, rd, er, lat);
        chk({name, "_rdata"}, rd, exp_rd);
        chk({name, "_err"}, 32'(er), 32'(exp_er));
        chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({name, "_writes"}, 32'(we_cnt - w0), 32'(exp_nw));
        idx = int'(addr >> 2);
        if (we && idx < 512) chk({name, "_word"}, mem[idx], ref_mem[idx]);
    endtask

    typedef struct {
        int          p;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rd;
        logic        er;
        int          lat;
    } vec_t;

    vec_t vt[13];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, nw, ng, nd, owner;
        int          order[4];
        logic [31:0] exp_tie[2];

        for (int i = 0; i < 512; i++) ref_mem[i] = 32'h0;
        vt[0]  = '{0, 1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 2};
        vt[1]  = '{0, 1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 2};
        vt[2]  = '{1, 1'b1, 32'h20,  32'h11223344, 4'hF, 32'h0, 1'b0, 2};
        vt[3]  = '{1, 1'b1, 32'h20,  32'hAABBCCDD, 4'h5, 32'h0, 1'b0, RMW ? 3 : 2};
        vt[4]  = '{1, 1'b0, 32'h20,  32'h0,        4'h0,
                   RMW ? 32'h11BB33DD : 32'hAABBCCDD, 1'b0, 2};
        vt[5]  = '{0, 1'b0, 32'h800, 32'h0,        4'h0, 32'h0, 1'b1, 2};
        vt[6]  = '{1, 1'b1, 32'h804, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1, 2};
        vt[7]  = '{0, 1'b1, 32'h7FF, 32'h12345678, 4'hF, 32'h0, 1'b0, 2};
        vt[8]  = '{1, 1'b0, 32'h7FC, 32'h0,        4'h0, 32'h12345678, 1'b0, 2};
        vt[9]  = '{0, 1'b1, 32'h10,  32'h0,        4'h0, 32'h0, 1'b0, 2};
        vt[10] = '{0, 1'b0, 32'h10,  32'h0,        4'h0,
                   RMW ? 32'hDEADBEEF : 32'h0, 1'b0, 2};
        vt[11] = '{0, 1'b1, 32'h40,  32'h55667788, 4'hF, 32'h0, 1'b0, 2};
        vt[12] = '{1, 1'b0, 32'h40,  32'h0,        4'h0, 32'h55667788, 1'b0, 2};

        rst = 1'b1;
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_gnt",   32'({m0_gnt, m1_gnt}), 32'h0);
        chk("rst_done",  32'({m0_done, m1_done}), 32'h0);
        chk("rst_err",   32'({m0_err, m1_err}), 32'h0);
        chk("rst_rdata", m0_rdata | m1_rdata, 32'h0);
        chk("rst_we",    32'(mem_we), 32'h0);
        chk("rst_addr",  mem_address, 32'h0);
        chk("rst_din",   mem_data_in, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            ref_txn(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, rd, er, lat, nw);
            run_check($sformatf("vec%0d", i), vt[i].p, vt[i].we, vt[i].addr, vt[i].wdata,
                      vt[i].be, vt[i].rd, vt[i].er, vt[i].lat, nw);
        end

        // Reset while the partial store is writing (MERGE, or ACCESS without RMW).
        @(negedge clk);
        drive(1, 1'b1, 32'h40, 32'hFFFFFFFF, 4'b0011, 1'b1);
        #1 chk("abort_gnt", 32'(m1_gnt), 32'd1);
        @(negedge clk);
        drive(1, 1'b1, 32'h40, 32'hFFFFFFFF, 4'b0011, 1'b0);
        if (RMW) @(negedge clk);
        chk("abort_we_pre", 32'(mem_we), 32'd1);
        rst = 1'b1;
        #1 chk("abort_we_drop", 32'(mem_we), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("abort_no_done", 32'({m0_done, m1_done}), 32'd0);
        chk("abort_word", mem[16], 32'h55667788);

        // Both ports held: grants alternate starting with port 0 after reset.
        exp_tie[0] = ref_mem[4];
        exp_tie[1] = ref_mem[8];
        ng = 0; nd = 0; owner = -1;
        @(negedge clk);
        drive(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
        drive(1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
        for (int c = 0; c < 40 && nd < 4; c++) begin
            if (ng == 4) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
            #1;
            if (m0_done || m1_done) begin
                chk("tie_done_port", 32'({m0_done, m1_done}), owner == 1 ? 32'd1 : 32'd2);
                chk("tie_rdata", owner == 1 ? m1_rdata : m0_rdata, exp_tie[owner == 1]);
                nd++;
            end
            if (m0_gnt || m1_gnt) begin
                if (m0_gnt && m1_gnt) chk("tie_both_gnt", 32'd1, 32'd0);
                if (ng < 4) order[ng] = int'(m1_gnt);
                ng++;
                owner = int'(m1_gnt);
            end
            @(negedge clk);
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        chk("tie_dones", 32'(nd), 32'd4);
        chk("tie_grants", 32'(ng), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("tie_order%0d", i), 32'(order[i]), 32'(i % 2));

        // Random single-port traffic against the reference model.
        for (int i = 0; i < 60; i++) begin
            int          p;
            logic        we;
            logic [29:0] idx;
            logic [31:0] addr, wdata;
            logic [3:0]  be;
            logic [31:0] erd;
            logic        eer;
            int          elat, enw;
            p     = int'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            idx   = ($urandom_range(0, 7) == 0) ? 30'($urandom_range(512, 1023))
                                                : 30'($urandom_range(0, 63));
            addr  = {idx, 2'($urandom_range(0, 3))};
            wdata = $urandom;
            be    = 4'($urandom_range(0, 15));
            ref_txn(we, addr, wdata, be, erd, eer, elat, enw);
            run_check($sformatf("rnd%0d", i), p, we, addr, wdata, be, erd, eer, elat, enw);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
